// File: rtl/clock_pkg.sv
// Shared types, field limits and packing offsets for the hh:mm:ss.cc timekeeping core.
package clock_pkg;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int FIELD_W = 8;

  localparam logic [FIELD_W-1:0] HH_MAX = 8'd23;
  localparam logic [FIELD_W-1:0] MM_MAX = 8'd59;
  localparam logic [FIELD_W-1:0] SS_MAX = 8'd59;
  localparam logic [FIELD_W-1:0] CC_MAX = 8'd99;

  localparam int HH_LSB = 24;
  localparam int MM_LSB = 16;
  localparam int SS_LSB = 8;
  localparam int CC_LSB = 0;

  // True when every packed field lies inside its counting range.
  function automatic logic time_valid(input logic [31:0] t);
    return (t[HH_LSB +: FIELD_W] <= HH_MAX) &&
           (t[MM_LSB +: FIELD_W] <= MM_MAX) &&
           (t[SS_LSB +: FIELD_W] <= SS_MAX) &&
           (t[CC_LSB +: FIELD_W] <= CC_MAX);
  endfunction

endpackage

// File: rtl/mod_n_field.sv
// One time field: 8-bit modulo-(MAX+1) counter with parallel load and carry-out.
module mod_n_field
  import clock_pkg::*;
#(
  parameter logic [FIELD_W-1:0] MAX = 8'd99
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_val,
  output logic [FIELD_W-1:0] value,
  output logic [FIELD_W-1:0] value_nxt,
  output logic               carry
);

  logic [FIELD_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (inc) begin
      value_d = (value_q == MAX) ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  // Carry is combinational so the whole cascade settles within one cycle.
  assign carry     = inc && (value_q == MAX);
  assign value     = value_q;
  assign value_nxt = value_d;

endmodule

// File: rtl/hms_time_counter.sv
// 10 ms prescaler, hh:mm:ss.cc cascade, STOP/RUN control and validated set handshake.
// Optional LAP_HOLD_EN: freezes the data output while lap=1 without stopping the count.
module hms_time_counter
  import clock_pkg::*;
#(
  parameter int T10MS = 250_000,
  parameter int PS_W  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        set_valid,
  input  logic [31:0] set_data,
  output logic        set_ready,
  output logic        set_err,
  input  logic        lap,
  output logic [31:0] data,
  output logic        tick_10ms,
  output logic        day_wrap,
  output logic        running
);

  state_e            state_q, state_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic              set_ready_q, set_ready_d;
  logic              running_q, running_d;
  logic              tick_q, day_wrap_q, set_err_q;

  logic              tc, set_fire, set_ok, load;
  logic              cc_carry, ss_carry, mm_carry, hh_carry;
  logic [FIELD_W-1:0] hh, mm, ss, cc;
  logic [FIELD_W-1:0] hh_nxt, mm_nxt, ss_nxt, cc_nxt;
  logic [31:0]       live_q, live_d;

  assign tc       = (state_q == ST_RUN) && (ps_q == PS_W'(T10MS - 1));
  assign set_fire = set_valid && set_ready_q;
  assign set_ok   = time_valid(set_data);
  assign load     = set_fire && set_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // stop has priority over start in every state.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_STOP;
    end else if (start) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    running_d   = (state_d == ST_RUN);
    set_ready_d = (state_d == ST_STOP);
  end

  // Prescaler holds in STOP so a resume completes the partial interval.
  always_comb begin
    ps_d = ps_q;
    if (load) begin
      ps_d = '0;
    end else if (state_q == ST_RUN) begin
      ps_d = tc ? '0 : ps_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q        <= '0;
      running_q   <= 1'b0;
      set_ready_q <= 1'b1;
      tick_q      <= 1'b0;
      day_wrap_q  <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      ps_q        <= ps_d;
      running_q   <= running_d;
      set_ready_q <= set_ready_d;
      tick_q      <= tc;
      day_wrap_q  <= hh_carry;
      set_err_q   <= set_fire && !set_ok;
    end
  end

  mod_n_field #(.MAX(CC_MAX)) u_cc (
    .clk(clk), .rst(rst), .inc(tc), .load(load),
    .load_val(set_data[CC_LSB +: FIELD_W]),
    .value(cc), .value_nxt(cc_nxt), .carry(cc_carry)
  );

  mod_n_field #(.MAX(SS_MAX)) u_ss (
    .clk(clk), .rst(rst), .inc(cc_carry), .load(load),
    .load_val(set_data[SS_LSB +: FIELD_W]),
    .value(ss), .value_nxt(ss_nxt), .carry(ss_carry)
  );

  mod_n_field #(.MAX(MM_MAX)) u_mm (
    .clk(clk), .rst(rst), .inc(ss_carry), .load(load),
    .load_val(set_data[MM_LSB +: FIELD_W]),
    .value(mm), .value_nxt(mm_nxt), .carry(mm_carry)
  );

  mod_n_field #(.MAX(HH_MAX)) u_hh (
    .clk(clk), .rst(rst), .inc(mm_carry), .load(load),
    .load_val(set_data[HH_LSB +: FIELD_W]),
    .value(hh), .value_nxt(hh_nxt), .carry(hh_carry)
  );

  assign live_q = {hh, mm, ss, cc};
  assign live_d = {hh_nxt, mm_nxt, ss_nxt, cc_nxt};

`ifdef LAP_HOLD_EN
  logic [31:0] data_q;

  // Loading from the next-state value keeps data aligned with tick_10ms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (load || !lap) begin
      data_q <= live_d;
    end
  end

  assign data = data_q;
`else
  logic unused_lap;
  logic [31:0] unused_live_d;

  assign unused_lap    = lap;
  assign unused_live_d = live_d;
  assign data          = live_q;
`endif

  assign set_ready = set_ready_q;
  assign set_err   = set_err_q;
  assign tick_10ms = tick_q;
  assign day_wrap  = day_wrap_q;
  assign running   = running_q;

endmodule
